lif_layer: RTL
==============

LIF_LAYER -- requirements
Module: lif_layer

Interface
REQ-001 Parameter N, default 4: number of neurons in the layer (1..16).
REQ-002 Parameter W, default 8: membrane, current and threshold width in bits (4..16).
REQ-003 Parameter LEAK_SHIFT, default 1: leak term is mem >> LEAK_SHIFT (1..W-1).
REQ-004 Parameter REFRAC, default 2: refractory length in valid timesteps (0..15).
REQ-005 Parameter RESET_MODE, default 0: post-spike membrane action; 0 = set to zero, 1 = subtract threshold.
REQ-006 clk  input  1: single clock; all state updates on its rising edge.
REQ-007 rst  input  1: reset, synchronous and active-high.
REQ-008 in_valid  input  1: one timestep of input is present this cycle.
REQ-009 current  input  N*W: unsigned per-neuron input current; neuron i uses bits [i*W +: W].
REQ-010 threshold  input  W: unsigned firing threshold shared by all neurons, sampled only when in_valid=1.
REQ-011 spike  output  N: registered spike vector; bit i is neuron i.
REQ-012 out_valid  output  1: spike and state reflect a completed timestep.
REQ-013 state  output  N*W: registered membrane values, same packing as current.
REQ-014 spike_total  output  16: saturating count of all spikes emitted since reset.

Function
REQ-015 The block SHALL update neurons only in cycles with in_valid=1; latency is 1 cycle, so out_valid SHALL equal in_valid delayed by one clock.
REQ-016 In cycles with in_valid=0, state and refractory counters SHALL hold, spike SHALL be 0, and out_valid SHALL be 0 in the following cycle.
REQ-017 Per neuron, if its refractory counter is nonzero, the counter SHALL decrement by 1, mem SHALL be forced to 0, current SHALL be ignored, and no spike SHALL occur.
REQ-018 Otherwise next = mem - (mem >> LEAK_SHIFT) + current, computed in W+1 bits and saturated to 2^W-1.
REQ-019 If next >= threshold, the neuron SHALL spike (spike bit = 1 for exactly one cycle) and load its refractory counter with REFRAC.
REQ-020 On spike, mem SHALL become 0 (RESET_MODE=0) or next - threshold (RESET_MODE=1); otherwise mem = next.
REQ-021 threshold = 0 SHALL cause a spike on every non-refractory valid timestep.
REQ-022 REFRAC = 0 SHALL allow a neuron to spike on consecutive valid timesteps.
REQ-023 spike_total SHALL add popcount(spike) in each update cycle and saturate at 16'hFFFF without wrapping.
REQ-024 All neurons SHALL update in parallel in the same cycle; neurons SHALL share no state except threshold.

Reset
REQ-025 When rst=1 at a clock edge, all mem, refractory counters, spike, out_valid and spike_total SHALL be 0 after that edge.
REQ-026 rst SHALL take priority over in_valid in the same cycle; the timestep presented that cycle SHALL be discarded.
REQ-027 Reset asserted mid-refractory or mid-accumulation SHALL fully clear state; no residual spike SHALL appear after release.

Verification (N=4, W=8, LEAK_SHIFT=1, REFRAC=2, RESET_MODE=0 unless stated)
REQ-028 Reset: rst high 2 cycles with in_valid=1, current=all 8'hFF -> spike=0, state=0, out_valid=0, spike_total=0.
REQ-029 Leak convergence: neuron0 current=40, thr=100, continuous valid -> state0 sequence 40,60,70,75,78,79,80,80...; no spike.
REQ-030 Refractory: neuron0 current=120, thr=100 -> spike on valid steps 1,4,7...; state0 = 0 between spikes; spike_total increments by 1 each spike.
REQ-031 Saturation: current=200, thr=255 -> step1 state=200, no spike; step2 next=300 saturates to 255, spike, state=0.
REQ-032 Gaps and subtract mode: RESET_MODE=1, REFRAC=0, current=150, thr=100, in_valid 1,0,0,1 -> step1 spike, state=50; idle cycles hold state=50 with out_valid=0; step2 next=175, spike, state=75.
REQ-033 Mid-operation reset: rst pulsed one cycle during neuron0 refractory -> all outputs 0; next valid with current=120 spikes immediately.

Source files
------------

// File: rtl/lif_layer.sv
// rtl/lif_layer.sv - layer of N leaky integrate-and-fire neurons with refractory period
// One timestep per in_valid cycle; spikes, membranes and a saturating spike count are registered.
module lif_layer #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int RESET_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N*W-1:0]   current,
    input  logic [W-1:0]     threshold,
    output logic [N-1:0]     spike,
    output logic             out_valid,
    output logic [N*W-1:0]   state,
    output logic [15:0]      spike_total
);

    localparam logic [3:0] REFRAC_L = 4'(REFRAC);

    logic [W-1:0]  mem_q   [N];
    logic [W-1:0]  mem_d   [N];
    logic [3:0]    ref_q   [N];
    logic [3:0]    ref_d   [N];
    logic [W:0]    sum_c   [N];
    logic [W-1:0]  next_c  [N];
    logic [N-1:0]  spike_q;
    logic [N-1:0]  spike_d;
    logic          out_valid_q;
    logic [15:0]   total_q;
    logic [15:0]   total_d;
    logic [4:0]    pop_c;
    logic [16:0]   total_sum_c;

    always_comb begin
        spike_d = '0;
        for (int i = 0; i < N; i++) begin
            mem_d[i] = mem_q[i];
            ref_d[i] = ref_q[i];
            // Leak and integrate in W+1 bits so overflow is visible before saturating.
            sum_c[i]  = {1'b0, mem_q[i]} - {1'b0, (mem_q[i] >> LEAK_SHIFT)}
                      + {1'b0, current[i*W +: W]};
            next_c[i] = sum_c[i][W] ? {W{1'b1}} : sum_c[i][W-1:0];
            if (in_valid) begin
                if (ref_q[i] != 4'd0) begin
                    ref_d[i] = ref_q[i] - 4'd1;
                    mem_d[i] = '0;
                end else if (next_c[i] >= threshold) begin
                    spike_d[i] = 1'b1;
                    ref_d[i]   = REFRAC_L;
                    mem_d[i]   = (RESET_MODE == 1) ? (next_c[i] - threshold) : '0;
                end else begin
                    mem_d[i] = next_c[i];
                end
            end
        end
    end

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < N; i++) begin
            pop_c = pop_c + 5'(spike_d[i]);
        end
        total_sum_c = {1'b0, total_q} + 17'(pop_c);
        total_d     = total_sum_c[16] ? 16'hFFFF : total_sum_c[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
                ref_q[i] <= '0;
            end
            spike_q     <= '0;
            out_valid_q <= 1'b0;
            total_q     <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= mem_d[i];
                ref_q[i] <= ref_d[i];
            end
            spike_q     <= spike_d;
            out_valid_q <= in_valid;
            total_q     <= total_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign state[g*W +: W] = mem_q[g];
    end

    assign spike       = spike_q;
    assign out_valid   = out_valid_q;
    assign spike_total = total_q;

endmodule
